// File: rtl/drp_pkg.sv
// Shared DRP definitions: FSM encoding, default widths and the ID register location.
package drp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } drp_state_e;

    localparam int DRP_ADDR_W = 6;
    localparam int DRP_DATA_W = 4;
    localparam logic [DRP_DATA_W-1:0] DRP_ID_VAL = 4'hA;

    // The ID register always sits at the top address of the bank.
    function automatic int drp_id_addr(input int aw);
        return (1 << aw) - 1;
    endfunction

    localparam int DRP_ID_ADDR = drp_id_addr(DRP_ADDR_W);

endpackage

// File: rtl/drp_regfile.sv
// DRP configuration bank: one write port, one combinational read port,
// with the top address decoded as a read-only ID register.
module drp_regfile
    import drp_pkg::*;
#(
    parameter int                ADDR_W = DRP_ADDR_W,
    parameter int                DATA_W = DRP_DATA_W,
    parameter logic [DATA_W-1:0] ID_VAL = DATA_W'(DRP_ID_VAL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int                DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ID_ADDR = ADDR_W'(drp_id_addr(ADDR_W));

    logic [DATA_W-1:0] bank [DEPTH];

    // Bank storage; writes to the ID address are dropped so it stays read-only.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
        end else if (we && (waddr != ID_ADDR)) begin
            bank[waddr] <= wdata;
        end
    end

    assign rdata = (raddr == ID_ADDR) ? ID_VAL : bank[raddr];

endmodule

// File: rtl/drp_target.sv
// DRP target endpoint: accepts DEN strobes from the DRP master, waits LAT
// cycles, completes the access against the register bank and pulses DRDY.
module drp_target
    import drp_pkg::*;
#(
    parameter int                ADDR_W = DRP_ADDR_W,
    parameter int                DATA_W = DRP_DATA_W,
    parameter int                LAT    = 2,
    parameter logic [DATA_W-1:0] ID_VAL = DATA_W'(DRP_ID_VAL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DEN,
    input  logic              DWE,
    input  logic [ADDR_W-1:0] DADDR,
    input  logic [DATA_W-1:0] DI,
    output logic              DRDY,
    output logic [DATA_W-1:0] DO,
    output logic              busy,
    output logic              err
);

    if (LAT < 0 || LAT > 15) begin : g_bad_lat
        $error("drp_target: LAT must be within 0..15");
    end

    localparam logic [3:0] LAT_CNT = 4'(LAT);

    drp_state_e        state;
    logic [3:0]        cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] di_q;
    logic [DATA_W-1:0] rdata;
    logic              rf_we;

    // The access completes on the edge that leaves DONE: the write lands in
    // the bank and the read data is captured together with DRDY. A request
    // accepted on that same edge is therefore always ordered after it.
    assign rf_we = (state == ST_DONE) && we_q;

    drp_regfile #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ID_VAL (ID_VAL)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (rf_we),
        .waddr (addr_q),
        .wdata (di_q),
        .raddr (addr_q),
        .rdata (rdata)
    );

    // busy is decoded straight from the state register, so it stays registered.
    assign busy = (state == ST_WAIT);

    // Request FSM: accept in IDLE/DONE, count wait states, complete from DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            di_q   <= '0;
            DRDY   <= 1'b0;
            DO     <= '0;
            err    <= 1'b0;
        end else begin
            DRDY <= 1'b0;
            DO   <= '0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (state == ST_DONE) begin
                        DRDY <= 1'b1;
                        DO   <= we_q ? '0 : rdata;
                    end
                    if (DEN) begin
                        we_q   <= DWE;
                        addr_q <= DADDR;
                        di_q   <= DI;
                        cnt    <= LAT_CNT;
                        state  <= (LAT == 0) ? ST_DONE : ST_WAIT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // A strobe here would clobber the in-flight request; flag it instead.
                    if (DEN) err <= 1'b1;
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
